// File: rtl/led_fill_monitor.sv
// Watches the bar pattern from a fill-up LED chaser, locks onto a correct
// fill sequence and counts protocol errors and full-bar wraps.
module led_fill_monitor #(
    parameter int LOCK_STEPS = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [7:0] Q_IN,
    output logic [3:0] LEVEL,
    output logic       LOCKED,
    output logic       ERR,
    output logic       WRAP,
    output logic [7:0] ERR_CNT,
    output logic [7:0] WRAP_CNT
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] ref_lvl;
    logic [3:0] good_cnt;

    logic       legal;
    logic [3:0] lvl;
    logic [3:0] succ_lvl;
    logic       is_succ;
    logic       err_evt;
    logic       wrap_evt;

    // A thermometer code has no set bit above a clear one, so x & (x+1) == 0.
    function automatic logic is_thermo(input logic [7:0] code);
        logic [7:0] next_code;
        next_code = code + 8'd1;
        return (code & next_code) == 8'd0;
    endfunction

    function automatic logic [3:0] ones(input logic [7:0] code);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, code[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        legal    = is_thermo(Q_IN);
        lvl      = ones(Q_IN);
        succ_lvl = (ref_lvl == 4'd8) ? 4'd0 : ref_lvl + 4'd1;
        is_succ  = legal && (lvl == succ_lvl);
        err_evt  = EN && (!legal || (state == LOCK && !is_succ));
        wrap_evt = EN && (state == LOCK) && is_succ && (ref_lvl == 4'd8);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ref_lvl  <= 4'd0;
            good_cnt <= 4'd0;
            LEVEL    <= 4'd0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            WRAP     <= 1'b0;
            ERR_CNT  <= 8'd0;
            WRAP_CNT <= 8'd0;
        end else begin
            ERR  <= err_evt;
            WRAP <= wrap_evt;
            if (err_evt) begin
                ERR_CNT <= sat_inc(ERR_CNT);
            end
            if (wrap_evt) begin
                WRAP_CNT <= sat_inc(WRAP_CNT);
            end
            if (EN) begin
                if (legal) begin
                    ref_lvl <= lvl;
                    LEVEL   <= lvl;
                end
                case (state)
                    IDLE: begin
                        if (legal) begin
                            state    <= SYNC;
                            good_cnt <= 4'd0;
                        end
                    end
                    SYNC: begin
                        if (is_succ) begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt + 4'd1 >= LOCK_N) begin
                                state  <= LOCK;
                                LOCKED <= 1'b1;
                            end
                        end else if (legal) begin
                            good_cnt <= 4'd0;
                        end else begin
                            state    <= IDLE;
                            good_cnt <= 4'd0;
                        end
                    end
                    LOCK: begin
                        if (!is_succ) begin
                            state    <= legal ? SYNC : IDLE;
                            good_cnt <= 4'd0;
                            LOCKED   <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        good_cnt <= 4'd0;
                        LOCKED   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/led_fill_monitor.md
LED_FILL_MONITOR -- requirements
Module: led_fill_monitor

Interface
REQ-001 Parameter LOCK_STEPS, default 3, number of consecutive correct fill steps required to declare lock; legal range 1..15.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high; clock CLK.
REQ-004 EN  input  1  sample strobe; Q_IN evaluated only on edges where EN=1.
REQ-005 Q_IN  input  8  observed LED bar pattern from the fill-up chaser.
REQ-006 LEVEL  output  4  number of lit LEDs (0..8) of the last legal sample.
REQ-007 LOCKED  output  1  high while the monitor tracks a correct fill sequence.
REQ-008 ERR  output  1  one-cycle pulse per counted error.
REQ-009 WRAP  output  1  one-cycle pulse per observed 0xFF -> 0x00 wrap while locked.
REQ-010 ERR_CNT  output  8  saturating error count.
REQ-011 WRAP_CNT  output  8  saturating wrap count.

Function
REQ-012 Legal codes SHALL be the 9 thermometer codes 0x00,0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F,0xFF; code level = number of ones; all other values are illegal.
REQ-013 Expected successor of level L SHALL be L+1 for L<8 and 0 for L=8.
REQ-014 FSM states SHALL be IDLE (no reference sample), SYNC (reference held, counting good steps), LOCK.
REQ-015 Edges with EN=0 SHALL hold all state, counters and LEVEL; ERR and WRAP SHALL be 0.
REQ-016 IDLE: legal sample -> SYNC, reference=sample, good_cnt=0; illegal sample -> stay IDLE, count error.
REQ-017 SYNC: sample equal to expected successor -> good_cnt+1; when good_cnt reaches LOCK_STEPS -> LOCK.
REQ-018 SYNC: legal non-successor -> stay SYNC, reference=sample, good_cnt=0, no error; illegal -> IDLE, count error.
REQ-019 LOCK: expected successor -> stay LOCK; legal non-successor -> SYNC, reference=sample, good_cnt=0, count error; illegal -> IDLE, count error.
REQ-020 Reference SHALL update to every legal sample in all states; illegal samples SHALL NOT update reference or LEVEL.
REQ-021 Counting an error SHALL assert ERR for exactly the cycle after the sampling edge and increment ERR_CNT, saturating at 255 (ERR still pulses when saturated).
REQ-022 In LOCK, a 0x00 sample following reference 0xFF SHALL assert WRAP for one cycle and increment WRAP_CNT, saturating at 255; wraps in SYNC count as good steps only.
REQ-023 All outputs SHALL be registered; latency from sampling edge to visible output is one clock (outputs valid after the edge that samples).
REQ-024 LOCKED SHALL equal (state==LOCK) and reflect the transition on the same edge that changes state.
REQ-025 EN held high with a static legal Q_IN SHALL be treated as a legal non-successor each edge (repeat is not a step).

Reset
REQ-026 RST=1 SHALL force IDLE, good_cnt=0, reference=0x00, LEVEL=0, LOCKED=0, ERR=0, WRAP=0, ERR_CNT=0, WRAP_CNT=0 on the next edge.
REQ-027 RST SHALL dominate EN; reset mid-sequence discards lock and counters with no ERR or WRAP pulse.

Verification
REQ-028 EN=1 each cycle, Q_IN 0x00,0x01,0x03,0x07 -> LOCKED=1 after the 0x07 edge, LEVEL=3, ERR_CNT=0.
REQ-029 Locked, Q_IN 0x7F,0xFF,0x00 -> WRAP pulses one cycle after 0x00 edge, WRAP_CNT=1, LEVEL=0, LOCKED stays 1.
REQ-030 Locked at 0x0F, Q_IN=0x1B (illegal) -> ERR one cycle, ERR_CNT=1, state IDLE, LOCKED=0, LEVEL stays 4.
REQ-031 Locked at 0x03, Q_IN=0x03 repeated -> ERR pulse, ERR_CNT+1, state SYNC, LOCKED=0; then 0x07,0x0F,0x1F -> relock.
REQ-032 300 illegal samples (0xAA) -> ERR_CNT=255 held, ERR pulses every sampled edge; EN toggled low mid-stream -> no change on EN=0 edges.
REQ-033 Locked with ERR_CNT=5, WRAP_CNT=2, assert RST one cycle with EN=1 -> all outputs 0, state IDLE next cycle.
